// File: rtl/gl_bram_read_arb_if.sv
// Bundles the request/grant/return signals of both BRAM requesters and the BRAM read port.
// Latency: none (wiring only).
// Backpressure: none here; the arbiter owns request/grant sequencing.
//
// Ports (as seen by the arbiter, modport slave):
//   if_req/if_addr     in   instruction fetch request and word address
//   if_gnt             out  fetch request accepted (1-cycle pulse)
//   if_valid/if_data   out  fetched word and its valid pulse
//   dt_req/dt_addr     in   operand burst request and base address
//   dt_gnt             out  burst request accepted (1-cycle pulse)
//   dt_valid           out  all four lanes valid (1-cycle pulse)
//   dt_data_0..3       out  burst lanes
//   busy               out  transaction in progress
//   bram_en/bram_addr  out  BRAM read enable and read address
//   bram_data_in       in   BRAM read data
// The master modport is the environment: both requesters plus the BRAM.
interface gl_bram_read_arb_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_data;
    logic        dt_req;
    logic [31:0] dt_addr;
    logic        dt_gnt;
    logic        dt_valid;
    logic [31:0] dt_data_0;
    logic [31:0] dt_data_1;
    logic [31:0] dt_data_2;
    logic [31:0] dt_data_3;
    logic        busy;
    logic        bram_en;
    logic [31:0] bram_addr;
    logic [31:0] bram_data_in;

    modport slave (
        input  if_req, if_addr, dt_req, dt_addr, bram_data_in,
        output if_gnt, if_valid, if_data, dt_gnt, dt_valid,
               dt_data_0, dt_data_1, dt_data_2, dt_data_3,
               busy, bram_en, bram_addr
    );

    modport master (
        output if_req, if_addr, dt_req, dt_addr, bram_data_in,
        input  if_gnt, if_valid, if_data, dt_gnt, dt_valid,
               dt_data_0, dt_data_1, dt_data_2, dt_data_3,
               busy, bram_en, bram_addr
    );
endinterface

// File: rtl/gl_bram_read_arb.sv
// Shares one BRAM read port between 1-word fetch reads and 4-word operand bursts.
// Latency: grant T, addresses from T+1, valid pulse at T+1+words+RD_LAT.
// Backpressure: requests wait while busy; gnt only from IDLE, round-robin on a tie.
//
// Ports: clk, reset (async, active-low) plus the gl_bram_read_arb_if slave
// modport carrying both requester handshakes, returned data and the BRAM port.
module gl_bram_read_arb #(
    parameter int RD_LAT    = 1,
    parameter int ADDR_STEP = 4,
    parameter int BURST     = 4
) (
    input  logic              clk,
    input  logic              reset,
    gl_bram_read_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    localparam logic [1:0]  LAST_IDX = 2'(BURST - 1);
    localparam logic [31:0] STEP     = 32'(ADDR_STEP);

    state_t                   state_q, state_d;
    logic                     rst_done_q, rst_done_d;
    logic                     last_dt_q, last_dt_d;
    logic                     txn_dt_q, txn_dt_d;
    logic [31:0]              base_q, base_d;
    logic [1:0]               cnt_q, cnt_d;
    logic [RD_LAT-1:0]        pipe_vld_q, pipe_vld_d;
    logic [RD_LAT-1:0]        pipe_last_q, pipe_last_d;
    logic [RD_LAT-1:0][1:0]   pipe_lane_q, pipe_lane_d;
    logic [31:0]              if_data_q, if_data_d;
    logic [3:0][31:0]         lane_q, lane_d;
    logic                     if_valid_q, if_valid_d;
    logic                     dt_valid_q, dt_valid_d;

    logic grant_if, grant_dt, issue, issue_last, cap, cap_last;

    always_comb begin
        grant_if    = 1'b0;
        grant_dt    = 1'b0;
        state_d     = state_q;
        rst_done_d  = 1'b1;
        last_dt_d   = last_dt_q;
        txn_dt_d    = txn_dt_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        pipe_vld_d  = pipe_vld_q;
        pipe_last_d = pipe_last_q;
        pipe_lane_d = pipe_lane_q;
        if_data_d   = if_data_q;
        lane_d      = lane_q;
        if_valid_d  = 1'b0;
        dt_valid_d  = 1'b0;

        // No grant until the first edge after reset release has been seen.
        if (state_q == IDLE && rst_done_q) begin
            if (bus.if_req && bus.dt_req) begin
                grant_dt = !last_dt_q;
                grant_if = last_dt_q;
            end else begin
                grant_if = bus.if_req;
                grant_dt = bus.dt_req;
            end
        end

        issue      = (state_q == ISSUE);
        issue_last = issue && (!txn_dt_q || cnt_q == LAST_IDX);
        cap        = pipe_vld_q[RD_LAT-1];
        cap_last   = cap && pipe_last_q[RD_LAT-1];

        case (state_q)
            IDLE: begin
                if (grant_if || grant_dt) begin
                    state_d   = ISSUE;
                    txn_dt_d  = grant_dt;
                    last_dt_d = grant_dt;
                    base_d    = grant_dt ? bus.dt_addr : bus.if_addr;
                    cnt_d     = 2'd0;
                end
            end
            ISSUE: begin
                if (issue_last) begin
                    state_d = DRAIN;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DRAIN: begin
                // The final word always lands after the last issue, so only DRAIN can see it.
                if (cap_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Tag pipe mirrors the BRAM latency: stage RD_LAT-1 lines up with its data.
        for (int i = RD_LAT - 1; i > 0; i--) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_last_d[i] = pipe_last_q[i-1];
            pipe_lane_d[i] = pipe_lane_q[i-1];
        end
        pipe_vld_d[0]  = issue;
        pipe_last_d[0] = issue_last;
        pipe_lane_d[0] = cnt_q;

        if (cap) begin
            if (txn_dt_q) lane_d[pipe_lane_q[RD_LAT-1]] = bus.bram_data_in;
            else          if_data_d                     = bus.bram_data_in;
        end
        if_valid_d = cap_last && !txn_dt_q;
        dt_valid_d = cap_last && txn_dt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rst_done_q  <= 1'b0;
            last_dt_q   <= 1'b0;
            txn_dt_q    <= 1'b0;
            base_q      <= '0;
            cnt_q       <= '0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
            pipe_lane_q <= '0;
            if_data_q   <= '0;
            lane_q      <= '0;
            if_valid_q  <= 1'b0;
            dt_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_done_q  <= rst_done_d;
            last_dt_q   <= last_dt_d;
            txn_dt_q    <= txn_dt_d;
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_last_q <= pipe_last_d;
            pipe_lane_q <= pipe_lane_d;
            if_data_q   <= if_data_d;
            lane_q      <= lane_d;
            if_valid_q  <= if_valid_d;
            dt_valid_q  <= dt_valid_d;
        end
    end

    assign bus.if_gnt    = grant_if;
    assign bus.dt_gnt    = grant_dt;
    assign bus.if_valid  = if_valid_q;
    assign bus.dt_valid  = dt_valid_q;
    assign bus.if_data   = if_data_q;
    assign bus.dt_data_0 = lane_q[0];
    assign bus.dt_data_1 = lane_q[1];
    assign bus.dt_data_2 = lane_q[2];
    assign bus.dt_data_3 = lane_q[3];
    assign bus.busy      = grant_if || grant_dt || (state_q != IDLE) || if_valid_q || dt_valid_q;
    assign bus.bram_en   = issue;
    // Burst addresses wrap modulo 2^32 through the natural 32-bit sum.
    assign bus.bram_addr = issue ? (base_q + STEP * {30'd0, cnt_q}) : 32'd0;
endmodule

// File: tb/tb_gl_bram_read_arb.sv
// Drives two arbiters (RD_LAT=1 and RD_LAT=3) against a BRAM model returning addr^0xA5A5.
// Expected addresses, valid timing, lane data and round-robin order come from a reference model.
// Directed scenarios first, then randomized fetch/burst/tie traffic.
module tb_gl_bram_read_arb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  if_req, dt_req;
    logic [31:0] if_addr [2];
    logic [31:0] dt_addr [2];
    logic [1:0]  if_gnt, dt_gnt, if_valid, dt_valid, busy, bram_en;
    logic [31:0] if_data [2];
    logic [31:0] bram_addr [2];
    logic [31:0] lane [2][4];

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit          last_dt_m [2];
    logic [31:0] exp_if [2];
    logic [31:0] exp_lane [2][4];

    always #5 clk = ~clk;

    function automatic logic [31:0] bram_f(input logic [31:0] a);
        return a ^ 32'h0000_A5A5;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : 3;
        gl_bram_read_arb_if bus ();
        logic [31:0] dly [3];

        gl_bram_read_arb #(.RD_LAT(L), .ADDR_STEP(4), .BURST(4)) u_dut (
            .clk   (clk),
            .reset (rst_n),
            .bus   (bus)
        );

        assign bus.if_req   = if_req[g];
        assign bus.if_addr  = if_addr[g];
        assign bus.dt_req   = dt_req[g];
        assign bus.dt_addr  = dt_addr[g];
        assign if_gnt[g]    = bus.if_gnt;
        assign dt_gnt[g]    = bus.dt_gnt;
        assign if_valid[g]  = bus.if_valid;
        assign dt_valid[g]  = bus.dt_valid;
        assign busy[g]      = bus.busy;
        assign bram_en[g]   = bus.bram_en;
        assign bram_addr[g] = bus.bram_addr;
        assign if_data[g]   = bus.if_data;
        assign lane[g][0]   = bus.dt_data_0;
        assign lane[g][1]   = bus.dt_data_1;
        assign lane[g][2]   = bus.dt_data_2;
        assign lane[g][3]   = bus.dt_data_3;

        // BRAM: address issued in cycle k appears as data during cycle k+L.
        always @(posedge clk) begin
            dly[0] <= bus.bram_en ? bus.bram_addr : 32'hDEAD_0000;
            dly[1] <= dly[0];
            dly[2] <= dly[1];
        end
        assign bus.bram_data_in = bram_f(dly[L-1]);
    end

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            last_dt_m[s] = 1'b0;
            exp_if[s]    = '0;
            for (int i = 0; i < 4; i++) exp_lane[s][i] = '0;
        end
    endtask

    task automatic chk_data(input string tag, input int s);
        chk32({tag, "_if_data"}, if_data[s], exp_if[s]);
        for (int i = 0; i < 4; i++) chk32({tag, "_lane"}, lane[s][i], exp_lane[s][i]);
    endtask

    task automatic chk_zero(input string tag);
        for (int s = 0; s < 2; s++) begin
            chk1({tag, "_if_gnt"}, if_gnt[s], 1'b0);
            chk1({tag, "_dt_gnt"}, dt_gnt[s], 1'b0);
            chk1({tag, "_if_valid"}, if_valid[s], 1'b0);
            chk1({tag, "_dt_valid"}, dt_valid[s], 1'b0);
            chk1({tag, "_busy"}, busy[s], 1'b0);
            chk1({tag, "_bram_en"}, bram_en[s], 1'b0);
            chk32({tag, "_bram_addr"}, bram_addr[s], 32'd0);
            chk_data(tag, s);
        end
    endtask

    // Waits (bounded) for a grant on DUT s and checks the winner against round-robin.
    task automatic wait_gnt(input int s, output bit wdt);
        bit exp_dt;
        int t;
        exp_dt = (if_req[s] && dt_req[s]) ? !last_dt_m[s] : dt_req[s];
        t = 0;
        @(negedge clk);
        while (!(if_gnt[s] || dt_gnt[s]) && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk1("gnt_seen", if_gnt[s] || dt_gnt[s], 1'b1);
        chk1("gnt_dt_winner", dt_gnt[s], exp_dt);
        chk1("gnt_if_winner", if_gnt[s], !exp_dt);
        chk1("gnt_busy", busy[s], 1'b1);
        last_dt_m[s] = exp_dt;
        wdt = exp_dt;
    endtask

    // Follows a granted transaction from T+1 through its valid cycle.
    task automatic follow(input int s, input bit dt, input logic [31:0] a, input bit glitch);
        int n, lat, v;
        bit nd;
        n   = dt ? 4 : 1;
        lat = (s == 0) ? 1 : 3;
        v   = n + lat + 1;
        for (int c = 1; c <= v; c++) begin
            @(negedge clk);
            chk1("busy", busy[s], 1'b1);
            chk1("bram_en", bram_en[s], c <= n);
            if (c <= n) chk32("bram_addr", bram_addr[s], a + 32'(4 * (c - 1)));
            chk1("if_valid", if_valid[s], !dt && c == v);
            chk1("dt_valid", dt_valid[s], dt && c == v);
            chk1("gnt_excl", if_gnt[s] && dt_gnt[s], 1'b0);
            if (c == 1) chk_data("hold", s);
            if (c < v) begin
                chk1("gnt_while_busy", if_gnt[s] || dt_gnt[s], 1'b0);
            end else begin
                nd = (if_req[s] && dt_req[s]) ? !last_dt_m[s] : dt_req[s];
                chk1("gnt_if_at_valid", if_gnt[s], if_req[s] && !nd);
                chk1("gnt_dt_at_valid", dt_gnt[s], nd);
                if (if_req[s] || dt_req[s]) last_dt_m[s] = nd;
                if (dt) for (int i = 0; i < 4; i++) exp_lane[s][i] = bram_f(a + 32'(4 * i));
                else    exp_if[s] = bram_f(a);
                chk_data("result", s);
            end
            // A request raised and dropped mid-transaction must leave no trace.
            if (glitch && v >= 4) begin
                if (c == 1) begin
                    if (dt) begin if_req[s] = 1'b1; if_addr[s] = $urandom; end
                    else    begin dt_req[s] = 1'b1; dt_addr[s] = $urandom; end
                end
                if (c == 2) begin
                    if_req[s] = 1'b0;
                    dt_req[s] = 1'b0;
                end
            end
        end
    endtask

    // One complete transaction; a losing requester withdraws after the grant.
    task automatic txn(input int s, input bit want_if, input logic [31:0] ia,
                       input bit want_dt, input logic [31:0] da, input bit glitch);
        bit wdt;
        @(posedge clk); #1;
        if_req[s] = want_if; if_addr[s] = ia;
        dt_req[s] = want_dt; dt_addr[s] = da;
        wait_gnt(s, wdt);
        @(posedge clk); #1;
        if_req[s] = 1'b0;
        dt_req[s] = 1'b0;
        follow(s, wdt, wdt ? da : ia, glitch);
        @(negedge clk);
        chk1("idle_busy", busy[s], 1'b0);
        chk1("idle_valid", if_valid[s] || dt_valid[s], 1'b0);
        chk1("idle_gnt", if_gnt[s] || dt_gnt[s], 1'b0);
        chk_data("idle", s);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          w;
        logic [31:0] a;
        int          s, mode;

        rst_n   = 1'b0;
        if_req  = '0;
        dt_req  = '0;
        for (int i = 0; i < 2; i++) begin if_addr[i] = '0; dt_addr[i] = '0; end
        model_reset();
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        // Single fetch and bursts, RD_LAT=1
        txn(0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
        chk32("sc1_if_data", if_data[0], 32'h0000_A5B5);
        txn(0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
        chk32("sc2_lane0", lane[0][0], 32'h0000_A4A5);
        chk32("sc2_lane3", lane[0][3], 32'h0000_A4A9);
        txn(0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8, 1'b0);
        chk32("sc4_lane2", lane[0][2], 32'h0000_A5A5);
        chk32("sc4_lane3", lane[0][3], 32'h0000_A5A1);

        // RD_LAT=3 repeats
        txn(1, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
        chk32("sc6_if_data", if_data[1], 32'h0000_A5B5);
        txn(1, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
        chk32("sc6_lane1", lane[1][1], 32'h0000_A4A1);

        // Both requesters held from reset: dt, if, dt, if
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        if_req[0] = 1'b1; if_addr[0] = 32'h20;
        dt_req[0] = 1'b1; dt_addr[0] = 32'h200;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_gnt(0, w);
        chk1("rr_1_dt", w, 1'b1);
        follow(0, 1'b1, 32'h200, 1'b0);
        chk1("rr_2_if", if_gnt[0], 1'b1);
        follow(0, 1'b0, 32'h20, 1'b0);
        chk1("rr_3_dt", dt_gnt[0], 1'b1);
        follow(0, 1'b1, 32'h200, 1'b0);
        chk1("rr_4_if", if_gnt[0], 1'b1);
        @(posedge clk); #1;
        if_req[0] = 1'b0;
        dt_req[0] = 1'b0;
        follow(0, 1'b0, 32'h20, 1'b0);

        // Reset in the middle of a burst
        @(posedge clk); #1;
        dt_req[0] = 1'b1; dt_addr[0] = 32'h300;
        wait_gnt(0, w);
        @(posedge clk); #1;
        dt_req[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk1("post_reset_dt_valid", dt_valid[0], 1'b0);
            chk1("post_reset_bram_en", bram_en[0], 1'b0);
        end
        txn(0, 1'b1, 32'h44, 1'b0, 32'h0, 1'b0);

        // Randomized traffic
        for (int k = 0; k < 24; k++) begin
            s    = int'($urandom_range(0, 1));
            mode = int'($urandom_range(0, 2));
            a    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3)))
                                               : $urandom;
            txn(s, mode != 1, $urandom, mode != 0, a, $urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
